// File: rtl/cond_flag_unit.sv
// NZCV flag register with EX->ID bypass, ARM condition evaluation into the ID/EX stage, annul counter.
// Latency: 1 cycle cond_in -> cond_pass_out; flags update 1 cycle after an S instruction retires.
// Backpressure: stall_in holds the ID/EX stage and the counter; flush_in inserts a bubble.
module cond_flag_unit #(
    parameter int COUNT_WIDTH = 16,
    parameter bit NV_PASS     = 1'b0
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic [3:0]             flags_in,
    input  logic                   s_in,
    input  logic                   ex_valid_in,
    input  logic [3:0]             cond_in,
    input  logic                   id_valid_in,
    input  logic                   stall_in,
    input  logic                   flush_in,
    output logic [3:0]             flags_reg_out,
    output logic                   carry_out,
    output logic                   valid_out,
    output logic                   cond_pass_out,
    output logic [COUNT_WIDTH-1:0] annul_count_out
);

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    logic       wr;
    logic [3:0] eff;
    logic       fn, fz, fc, fv;
    logic       cond_ok;

    // A flag write retiring this cycle is visible to the instruction in ID now.
    always_comb begin
        wr  = ex_valid_in & s_in;
        eff = wr ? flags_in : flags_reg_out;
        fv  = eff[3];
        fc  = eff[2];
        fz  = eff[1];
        fn  = eff[0];
        cond_ok = 1'b0;
        case (cond_in)
            4'b0000: cond_ok = fz;
            4'b0001: cond_ok = ~fz;
            4'b0010: cond_ok = fc;
            4'b0011: cond_ok = ~fc;
            4'b0100: cond_ok = fn;
            4'b0101: cond_ok = ~fn;
            4'b0110: cond_ok = fv;
            4'b0111: cond_ok = ~fv;
            4'b1000: cond_ok = fc & ~fz;
            4'b1001: cond_ok = ~fc | fz;
            4'b1010: cond_ok = (fn == fv);
            4'b1011: cond_ok = (fn != fv);
            4'b1100: cond_ok = ~fz & (fn == fv);
            4'b1101: cond_ok = fz | (fn != fv);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = NV_PASS;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            flags_reg_out   <= 4'b0000;
            valid_out       <= 1'b0;
            cond_pass_out   <= 1'b0;
            annul_count_out <= '0;
        end else begin
            if (wr)
                flags_reg_out <= flags_in;
            if (flush_in) begin
                valid_out     <= 1'b0;
                cond_pass_out <= 1'b0;
            end else if (!stall_in) begin
                valid_out     <= id_valid_in;
                cond_pass_out <= id_valid_in & cond_ok;
                if (id_valid_in && !cond_ok && annul_count_out != CNT_MAX)
                    annul_count_out <= annul_count_out + CNT_ONE;
            end
        end
    end

    // Registered only: an EX instruction never sees its own flags_in as carry.
    assign carry_out = flags_reg_out[2];

endmodule

// File: tb/tb_cond_flag_unit.sv
// Bench for cond_flag_unit: directed literal cases plus randomized traffic against a behavioural model.
// Two instances share stimulus: defaults, and COUNT_WIDTH=2 / NV_PASS=1.
module tb_cond_flag_unit;

    logic       clk = 1'b0;
    logic       reset, s, exv, idv, stall, flush;
    logic [3:0] flags, cond;

    logic [3:0]  a_flags, b_flags;
    logic        a_carry, b_carry, a_valid, b_valid, a_pass, b_pass;
    logic [15:0] a_cnt;
    logic [1:0]  b_cnt;

    int tests = 0;
    int fails = 0;

    // model state
    logic [3:0] m_flags = 4'b0;
    bit m_valid = 0, m_pass_a = 0, m_pass_b = 0;
    int m_cnt_a = 0, m_cnt_b = 0;

    always #5 clk = ~clk;

    cond_flag_unit #(.COUNT_WIDTH(16), .NV_PASS(1'b0)) dut_a (
        .clk_in(clk), .reset_in(reset), .flags_in(flags), .s_in(s), .ex_valid_in(exv),
        .cond_in(cond), .id_valid_in(idv), .stall_in(stall), .flush_in(flush),
        .flags_reg_out(a_flags), .carry_out(a_carry), .valid_out(a_valid),
        .cond_pass_out(a_pass), .annul_count_out(a_cnt));

    cond_flag_unit #(.COUNT_WIDTH(2), .NV_PASS(1'b1)) dut_b (
        .clk_in(clk), .reset_in(reset), .flags_in(flags), .s_in(s), .ex_valid_in(exv),
        .cond_in(cond), .id_valid_in(idv), .stall_in(stall), .flush_in(flush),
        .flags_reg_out(b_flags), .carry_out(b_carry), .valid_out(b_valid),
        .cond_pass_out(b_pass), .annul_count_out(b_cnt));

    // Conditions come in base/inverse pairs: odd codes negate the even one below.
    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f, input bit nvp);
        bit n, z, cy, v, base;
        n = f[0]; z = f[1]; cy = f[2]; v = f[3];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return c[0] ? nvp : 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("flags_a", int'(a_flags), int'(m_flags));
        chk("carry_a", int'(a_carry), int'(m_flags[2]));
        chk("valid_a", int'(a_valid), int'(m_valid));
        chk("pass_a",  int'(a_pass),  int'(m_pass_a));
        chk("cnt_a",   int'(a_cnt),   m_cnt_a);
        chk("flags_b", int'(b_flags), int'(m_flags));
        chk("valid_b", int'(b_valid), int'(m_valid));
        chk("pass_b",  int'(b_pass),  int'(m_pass_b));
        chk("cnt_b",   int'(b_cnt),   m_cnt_b);
    endtask

    // Advance one clock: model consumes the inputs present at the edge, then compare.
    task automatic tick();
        bit wr, pa, pb;
        logic [3:0] eff;
        wr  = exv && s;
        eff = wr ? flags : m_flags;
        pa  = cond_holds(cond, eff, 1'b0);
        pb  = cond_holds(cond, eff, 1'b1);
        @(posedge clk);
        #1;
        if (reset) begin
            m_flags = 0; m_valid = 0; m_pass_a = 0; m_pass_b = 0; m_cnt_a = 0; m_cnt_b = 0;
        end else begin
            if (wr) m_flags = flags;
            if (flush) begin
                m_valid = 0; m_pass_a = 0; m_pass_b = 0;
            end else if (!stall) begin
                m_valid  = idv;
                m_pass_a = idv && pa;
                m_pass_b = idv && pb;
                if (idv && !pa && m_cnt_a < 65535) m_cnt_a++;
                if (idv && !pb && m_cnt_b < 3) m_cnt_b++;
            end
        end
        compare_model();
    endtask

    task automatic drive(input bit r, input bit e, input bit sb, input logic [3:0] f,
                         input bit iv, input logic [3:0] c, input bit st, input bit fl);
        reset = r; exv = e; s = sb; flags = f; idv = iv; cond = c; stall = st; flush = fl;
    endtask

    task automatic set_flags(input logic [3:0] f);
        drive(0, 1, 1, f, 0, 4'hE, 0, 0);
        tick();
    endtask

    task automatic eval(input logic [3:0] c);
        drive(0, 0, 0, 4'h0, 1, c, 0, 0);
        tick();
    endtask

    initial begin
        drive(1, 1, 1, 4'hF, 0, 4'h0, 0, 0);
        // reset with a pending flag write
        tick(); tick();
        chk("rst_flags", int'(a_flags), 0);
        chk("rst_valid", int'(a_valid), 0);
        chk("rst_pass",  int'(a_pass), 0);
        chk("rst_cnt",   int'(a_cnt), 0);

        // bypass: Z written this cycle satisfies EQ in ID
        drive(0, 1, 1, 4'b0010, 1, 4'b0000, 0, 0);
        tick();
        chk("byp_flags", int'(a_flags), 2);
        chk("byp_pass",  int'(a_pass), 1);
        chk("byp_carry", int'(a_carry), 0);

        // no S bit: flags hold, NE fails on Z=1
        drive(0, 1, 0, 4'b0000, 1, 4'b0001, 0, 0);
        tick();
        chk("nos_flags", int'(a_flags), 2);
        chk("nos_pass",  int'(a_pass), 0);
        chk("nos_cnt",   int'(a_cnt), 1);

        // signed conditions with V=1
        set_flags(4'b1000);
        eval(4'b1010); chk("ge_v", int'(a_pass), 0);
        eval(4'b1011); chk("lt_v", int'(a_pass), 1);
        eval(4'b1100); chk("gt_v", int'(a_pass), 0);
        eval(4'b1101); chk("le_v", int'(a_pass), 1);
        set_flags(4'b0100);
        chk("carry_c", int'(a_carry), 1);
        eval(4'b1000); chk("hi_c", int'(a_pass), 1);
        eval(4'b1001); chk("ls_c", int'(a_pass), 0);
        chk("cnt_sig", int'(a_cnt), 4);

        // stall holds stage and counter while cond toggles
        eval(4'b1110);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 4'h0, 1, (i % 2 == 0) ? 4'b0011 : 4'b0000, 1, 0);
            tick();
            chk("stl_valid", int'(a_valid), 1);
            chk("stl_pass",  int'(a_pass), 1);
            chk("stl_cnt",   int'(a_cnt), 4);
        end
        drive(0, 0, 0, 4'h0, 1, 4'b1110, 1, 1);
        tick();
        chk("fl_valid", int'(a_valid), 0);
        chk("fl_pass",  int'(a_pass), 0);

        // saturation on the 2-bit instance; EQ fails with flags cleared
        drive(1, 0, 0, 4'h0, 0, 4'h0, 0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            eval(4'b0000);
            chk("sat_cnt_b", int'(b_cnt), (i < 3) ? i + 1 : 3);
            chk("sat_cnt_a", int'(a_cnt), i + 1);
        end
        eval(4'b1111);
        chk("nv_pass0", int'(a_pass), 0);
        chk("nv_pass1", int'(b_pass), 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(99) < 2), $urandom_range(1), $urandom_range(1),
                  4'($urandom_range(15)), ($urandom_range(99) < 80), 4'($urandom_range(15)),
                  ($urandom_range(99) < 25), ($urandom_range(99) < 10));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
